// File: rtl/pwm_pkg.sv
// Shared constants for the multi-channel centre-aligned PWM block.
// Load kind encodings and the minimum legal period.
package pwm_pkg;

  localparam logic [1:0] KIND_DUTY   = 2'd0;
  localparam logic [1:0] KIND_DELAY  = 2'd1;
  localparam logic [1:0] KIND_PERIOD = 2'd2;

  localparam int unsigned PERIOD_MIN = 2;

endpackage

// File: rtl/pwm_delay_line.sv
// Per-channel programmable delay: dout is din delayed by 'delay' cycles,
// with delay 0 passing din straight through.
module pwm_delay_line #(
  parameter int unsigned  MAX_DELAY = 15,
  localparam int unsigned DLY_W     = $clog2(MAX_DELAY + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             din,
  input  logic [DLY_W-1:0] delay,
  output logic             dout
);

  logic [MAX_DELAY-1:0] shift_q;
  logic [MAX_DELAY:0]   taps;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shift_q <= '0;
    end else begin
      shift_q <= MAX_DELAY'({shift_q, din});
    end
  end

  // taps[k] is din as it was k cycles ago; the writer saturates delay to MAX_DELAY.
  assign taps = {shift_q, din};
  assign dout = taps[delay];

endmodule

// File: rtl/pwm_multi.sv
// Multi-channel centre-aligned PWM: one shared up/down counter, duty and period
// double-buffered and applied at the valley, plus a delay line per channel.
module pwm_multi
  import pwm_pkg::*;
#(
  parameter int unsigned  WIDTH      = 12,
  parameter int unsigned  NCH        = 4,
  parameter int unsigned  PERIOD_DEF = 1000,
  parameter int unsigned  MAX_DELAY  = 15,
  localparam int unsigned CH_W       = (NCH > 1) ? $clog2(NCH) : 1,
  localparam int unsigned DLY_W      = $clog2(MAX_DELAY + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             enable,
  input  logic             load_en,
  input  logic [1:0]       load_kind,
  input  logic [CH_W-1:0]  load_ch,
  input  logic [WIDTH-1:0] load,
  output logic [NCH-1:0]   pwm,
  output logic [NCH-1:0]   delayed,
  output logic             valley,
  output logic [WIDTH-1:0] counter
);

  // load_en is asynchronous: two-flop synchroniser then an edge register.
  logic load_meta_q, load_s1_q, load_s2_q;
  logic load_rise;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      load_meta_q <= 1'b0;
      load_s1_q   <= 1'b0;
      load_s2_q   <= 1'b0;
    end else begin
      load_meta_q <= load_en;
      load_s1_q   <= load_meta_q;
      load_s2_q   <= load_s1_q;
    end
  end

  assign load_rise = load_s1_q & ~load_s2_q;

  logic             ch_ok;
  logic             wr_duty, wr_delay, wr_period;
  logic [WIDTH-1:0] period_wdata;
  logic [DLY_W-1:0] delay_wdata;

  assign ch_ok        = int'(load_ch) < int'(NCH);
  assign wr_duty      = load_rise && (load_kind == KIND_DUTY) && ch_ok;
  assign wr_delay     = load_rise && (load_kind == KIND_DELAY) && ch_ok;
  assign wr_period    = load_rise && (load_kind == KIND_PERIOD);
  assign period_wdata = (32'(load) < PERIOD_MIN) ? WIDTH'(PERIOD_MIN) : load;
  assign delay_wdata  = (32'(load) > MAX_DELAY) ? DLY_W'(MAX_DELAY) : DLY_W'(load);

  logic [WIDTH-1:0] cnt_q, cnt_d;
  logic             cnt_up_q, cnt_up_d;
  logic [WIDTH-1:0] period_sh_q, period_act_q;
  logic [WIDTH-1:0] duty_sh_q  [NCH];
  logic [WIDTH-1:0] duty_act_q [NCH];
  logic [DLY_W-1:0] delay_q    [NCH];
  logic [NCH-1:0]   pwm_q, pwm_d;
  logic             valley_q, valley_d;
  logic             xfer;

  // Actives follow the shadows at every valley, and continuously while stopped.
  assign xfer = !enable || (cnt_q == '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      period_sh_q  <= WIDTH'(PERIOD_DEF);
      period_act_q <= WIDTH'(PERIOD_DEF);
      for (int c = 0; c < NCH; c++) begin
        duty_sh_q[c]  <= '0;
        duty_act_q[c] <= '0;
        delay_q[c]    <= '0;
      end
    end else begin
      if (xfer) begin
        period_act_q <= period_sh_q;
        for (int c = 0; c < NCH; c++) begin
          duty_act_q[c] <= duty_sh_q[c];
        end
      end
      if (wr_period) begin
        period_sh_q <= period_wdata;
      end
      for (int c = 0; c < NCH; c++) begin
        if (wr_duty && (int'(load_ch) == c)) begin
          duty_sh_q[c] <= load;
        end
        if (wr_delay && (int'(load_ch) == c)) begin
          delay_q[c] <= delay_wdata;
        end
      end
    end
  end

  always_comb begin
    cnt_d    = cnt_q;
    cnt_up_d = cnt_up_q;
    if (!enable) begin
      cnt_d    = '0;
      cnt_up_d = 1'b1;
    end else if (cnt_up_q) begin
      if (cnt_q >= period_act_q) begin
        cnt_d    = cnt_q - WIDTH'(1);
        cnt_up_d = 1'b0;
      end else begin
        cnt_d = cnt_q + WIDTH'(1);
      end
    end else begin
      if (cnt_q == '0) begin
        cnt_d    = WIDTH'(1);
        cnt_up_d = 1'b1;
      end else begin
        cnt_d = cnt_q - WIDTH'(1);
      end
    end
  end

  always_comb begin
    pwm_d    = '0;
    valley_d = enable && (cnt_q == '0);
    for (int c = 0; c < NCH; c++) begin
      pwm_d[c] = enable && (cnt_q < duty_act_q[c]);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q    <= '0;
      cnt_up_q <= 1'b1;
      pwm_q    <= '0;
      valley_q <= 1'b0;
    end else begin
      cnt_q    <= cnt_d;
      cnt_up_q <= cnt_up_d;
      pwm_q    <= pwm_d;
      valley_q <= valley_d;
    end
  end

  for (genvar c = 0; c < NCH; c++) begin : g_dly
    pwm_delay_line #(
      .MAX_DELAY(MAX_DELAY)
    ) u_dly (
      .clk  (clk),
      .rst_n(rst_n),
      .din  (pwm_q[c]),
      .delay(delay_q[c]),
      .dout (delayed[c])
    );
  end

  assign pwm     = pwm_q;
  assign valley  = valley_q;
  assign counter = cnt_q;

endmodule
